// File: rtl/hazard_pkg.sv
// Shared constants and scoreboard entry type for the decode-stage hazard scoreboard.
package hazard_pkg;

    localparam int unsigned REG_ADDR_W_DEFAULT = 4;
    localparam int unsigned STALL_CNT_W        = 16;

    typedef struct packed {
        logic                          v;
        logic [REG_ADDR_W_DEFAULT-1:0] ws;
    } sb_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one decode read selector against every in-flight scoreboard entry.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEFAULT,
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned ZERO_REG_EN = 0
) (
    input  logic                               re,
    input  logic [REG_ADDR_W-1:0]              rs,
    input  logic [NUM_STAGES-1:0]              v,
    input  logic [NUM_STAGES*REG_ADDR_W-1:0]   ws,
    output logic                               hit
);

    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (v[i] && (ws[i*REG_ADDR_W +: REG_ADDR_W] == rs)) begin
                hit = 1'b1;
            end
        end
        if (!re || ((ZERO_REG_EN != 0) && (rs == '0))) begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall unit with an internal shift-register scoreboard of in-flight writes.
// Optional stall-cycle counter enabled by defining HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEFAULT,
    parameter int unsigned NUM_READ    = 2,
    parameter int unsigned NUM_STAGES  = 2,
    parameter int unsigned ZERO_REG_EN = 0
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_decoder_valid,
    input  logic [NUM_READ-1:0]            i_decoder_re,
    input  logic [NUM_READ*REG_ADDR_W-1:0] i_decoder_rs,
    input  logic                           i_decoder_we,
    input  logic [REG_ADDR_W-1:0]          i_decoder_ws,
    input  logic                           i_flush,
`ifdef HAZARD_SCOREBOARD_PERF_EN
    input  logic                           i_perf_clr,
    output logic [STALL_CNT_W-1:0]         o_stall_cycles,
`endif
    output logic                           o_stall,
    output logic [NUM_STAGES-1:0]          o_pending
);

    logic [NUM_STAGES-1:0]            v_q;
    logic [NUM_STAGES*REG_ADDR_W-1:0] ws_q;
    logic [NUM_READ-1:0]              hit;

    for (genvar k = 0; k < NUM_READ; k++) begin : g_port
        hazard_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .NUM_STAGES (NUM_STAGES),
            .ZERO_REG_EN(ZERO_REG_EN)
        ) u_match (
            .re (i_decoder_re[k]),
            .rs (i_decoder_rs[k*REG_ADDR_W +: REG_ADDR_W]),
            .v  (v_q),
            .ws (ws_q),
            .hit(hit[k])
        );
    end

    always_comb begin
        o_stall = i_decoder_valid && !i_flush && (|hit);
    end

    // Flush drops the decode instruction too, so nothing is inserted on that edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_flush) begin
            v_q  <= '0;
            ws_q <= '0;
        end else begin
            for (int unsigned i = NUM_STAGES - 1; i > 0; i--) begin
                v_q[i]                            <= v_q[i-1];
                ws_q[i*REG_ADDR_W +: REG_ADDR_W]  <= ws_q[(i-1)*REG_ADDR_W +: REG_ADDR_W];
            end
            v_q[0]               <= i_decoder_valid && i_decoder_we && !o_stall;
            ws_q[REG_ADDR_W-1:0] <= i_decoder_ws;
        end
    end

    always_comb begin
        o_pending = v_q;
    end

`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n || i_perf_clr) begin
            stall_cnt <= '0;
        end else if (o_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

    always_comb begin
        o_stall_cycles = stall_cnt;
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed vector table plus random traffic against a queue-based model.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int unsigned W  = REG_ADDR_W_DEFAULT;
    localparam int unsigned NR = 2;
    localparam int unsigned NS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic [NR-1:0] re = '0;
    logic [NR*W-1:0] rs = '0;
    logic          we = 1'b0;
    logic [W-1:0]  ws = '0;
    logic          flush = 1'b0;
    logic          stall, stall_z;
    logic [NS-1:0] pend, pend_z;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    logic          perf_clr = 1'b0;
    logic [STALL_CNT_W-1:0] cyc, cyc_z;
    int unsigned   m_cnt = 0, m_cnt_z = 0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(W), .NUM_READ(NR), .NUM_STAGES(NS), .ZERO_REG_EN(0)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_decoder_valid(valid), .i_decoder_re(re),
        .i_decoder_rs(rs), .i_decoder_we(we), .i_decoder_ws(ws), .i_flush(flush),
`ifdef HAZARD_SCOREBOARD_PERF_EN
        .i_perf_clr(perf_clr), .o_stall_cycles(cyc),
`endif
        .o_stall(stall), .o_pending(pend)
    );

    hazard_scoreboard #(.REG_ADDR_W(W), .NUM_READ(NR), .NUM_STAGES(NS), .ZERO_REG_EN(1)) dut_z (
        .i_clk(clk), .i_reset_n(rst_n), .i_decoder_valid(valid), .i_decoder_re(re),
        .i_decoder_rs(rs), .i_decoder_we(we), .i_decoder_ws(ws), .i_flush(flush),
`ifdef HAZARD_SCOREBOARD_PERF_EN
        .i_perf_clr(perf_clr), .o_stall_cycles(cyc_z),
`endif
        .o_stall(stall_z), .o_pending(pend_z)
    );

    // Reference model: queue of in-flight writes, index 0 = youngest.
    typedef sb_entry_t q_t[$];
    q_t qa, qz;

    typedef struct {
        logic          v;
        logic [NR-1:0] re;
        logic [W-1:0]  rs1, rs0;
        logic          we;
        logic [W-1:0]  ws;
        logic          fl;
        logic          st, zst;
        logic [NS-1:0] pd;
    } vec_t;
    vec_t tbl[30];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic m_stall(q_t q, bit zen);
        logic         s = 1'b0;
        logic [W-1:0] r;
        foreach (q[i]) begin
            for (int k = 0; k < NR; k++) begin
                r = rs[k*W +: W];
                if (re[k] && q[i].v && q[i].ws == r && !(zen && r == '0)) s = 1'b1;
            end
        end
        return valid && !flush && s;
    endfunction

    function automatic q_t m_next(q_t q, logic st);
        q_t n;
        sb_entry_t e;
        if (!rst_n || flush) begin
            n = {};
            for (int i = 0; i < NS; i++) n.push_back('0);
        end else begin
            n = q;
            e.v  = valid && we && !st;
            e.ws = ws;
            n.push_front(e);
            void'(n.pop_back());
        end
        return n;
    endfunction

    function automatic logic [NS-1:0] m_pend(q_t q);
        logic [NS-1:0] p = '0;
        foreach (q[i]) p[i] = q[i].v;
        return p;
    endfunction

    task automatic apply(input logic v, input logic [NR-1:0] r_en, input logic [W-1:0] r1,
                         input logic [W-1:0] r0, input logic w_en, input logic [W-1:0] w_sel,
                         input logic fl);
        valid = v; re = r_en; rs = {r1, r0}; we = w_en; ws = w_sel; flush = fl;
    endtask

    task automatic rand_in();
        valid = ($urandom_range(0, 3) != 0);
        re    = NR'($urandom);
        for (int k = 0; k < NR; k++) rs[k*W +: W] = W'($urandom_range(0, 7));
        we    = $urandom_range(0, 1) == 1;
        ws    = W'($urandom_range(0, 7));
        flush = ($urandom_range(0, 15) == 0);
    endtask

    task automatic step(input bit do_chk, input bit has_exp, input logic e_st,
                        input logic e_zst, input logic [NS-1:0] e_pd);
        logic ma, mz;
        q_t   na, nz;
        #3;
        ma = m_stall(qa, 1'b0);
        mz = m_stall(qz, 1'b1);
        if (has_exp) begin
            chk("tbl_stall", stall, e_st);
            chk("tbl_pending", pend, e_pd);
            chk("tbl_zero_stall", stall_z, e_zst);
        end
        if (do_chk) begin
            chk("model_stall", stall, ma);
            chk("model_pending", pend, m_pend(qa));
            chk("model_zero_stall", stall_z, mz);
            chk("model_zero_pending", pend_z, m_pend(qz));
`ifdef HAZARD_SCOREBOARD_PERF_EN
            chk("model_stall_cycles", cyc, m_cnt);
            chk("model_zero_stall_cycles", cyc_z, m_cnt_z);
`endif
        end
        na = m_next(qa, ma);
        nz = m_next(qz, mz);
`ifdef HAZARD_SCOREBOARD_PERF_EN
        if (!rst_n || perf_clr) begin
            m_cnt = 0; m_cnt_z = 0;
        end else begin
            if (ma && m_cnt < 32'hFFFF) m_cnt++;
            if (mz && m_cnt_z < 32'hFFFF) m_cnt_z++;
        end
`endif
        @(posedge clk);
        #1;
        qa = na;
        qz = nz;
    endtask

    initial begin
        //          v  re     rs1 rs0 we ws fl  st zst pd
        tbl[0]  = '{1, 2'b00, 0,  0,  1, 3, 0,  0, 0,  2'b00};
        tbl[1]  = '{1, 2'b01, 0,  3,  0, 0, 0,  1, 1,  2'b01};
        tbl[2]  = '{1, 2'b01, 0,  3,  0, 0, 0,  1, 1,  2'b10};
        tbl[3]  = '{1, 2'b01, 0,  3,  0, 0, 0,  0, 0,  2'b00};
        tbl[4]  = '{0, 2'b00, 0,  0,  0, 0, 0,  0, 0,  2'b00};
        tbl[5]  = '{1, 2'b00, 0,  0,  1, 5, 0,  0, 0,  2'b00};
        tbl[6]  = '{1, 2'b11, 1,  2,  1, 6, 0,  0, 0,  2'b01};
        tbl[7]  = '{1, 2'b10, 5,  0,  0, 0, 0,  1, 1,  2'b11};
        tbl[8]  = '{1, 2'b10, 5,  0,  0, 0, 0,  0, 0,  2'b10};
        tbl[9]  = '{0, 2'b00, 0,  0,  0, 0, 0,  0, 0,  2'b00};
        tbl[10] = '{1, 2'b00, 0,  0,  1, 7, 0,  0, 0,  2'b00};
        tbl[11] = '{1, 2'b01, 0,  7,  0, 0, 1,  0, 0,  2'b01};
        tbl[12] = '{0, 2'b00, 0,  0,  0, 0, 0,  0, 0,  2'b00};
        tbl[13] = '{1, 2'b00, 0,  0,  1, 2, 0,  0, 0,  2'b00};
        tbl[14] = '{1, 2'b00, 2,  2,  0, 0, 0,  0, 0,  2'b01};
        tbl[15] = '{1, 2'b10, 2,  0,  0, 0, 0,  1, 1,  2'b10};
        tbl[16] = '{1, 2'b10, 2,  0,  0, 0, 0,  0, 0,  2'b00};
        tbl[17] = '{1, 2'b01, 0,  4,  1, 4, 0,  0, 0,  2'b00};
        tbl[18] = '{0, 2'b00, 0,  0,  0, 0, 0,  0, 0,  2'b01};
        tbl[19] = '{1, 2'b00, 0,  0,  1, 9, 0,  0, 0,  2'b10};
        tbl[20] = '{1, 2'b00, 0,  0,  1, 8, 0,  0, 0,  2'b01};
        tbl[21] = '{1, 2'b11, 8,  9,  0, 0, 0,  1, 1,  2'b11};
        tbl[22] = '{1, 2'b11, 8,  9,  0, 0, 0,  1, 1,  2'b10};
        tbl[23] = '{1, 2'b11, 8,  9,  0, 0, 0,  0, 0,  2'b00};
        tbl[24] = '{0, 2'b11, 0,  0,  1, 1, 0,  0, 0,  2'b00};
        tbl[25] = '{1, 2'b01, 0,  1,  0, 0, 0,  0, 0,  2'b00};
        tbl[26] = '{1, 2'b00, 0,  0,  1, 0, 0,  0, 0,  2'b00};
        tbl[27] = '{1, 2'b01, 0,  0,  0, 0, 0,  1, 0,  2'b01};
        tbl[28] = '{0, 2'b00, 0,  0,  0, 0, 0,  0, 0,  2'b10};
        tbl[29] = '{0, 2'b00, 0,  0,  0, 0, 0,  0, 0,  2'b00};

        qa = {}; qz = {};
        for (int i = 0; i < NS; i++) begin
            qa.push_back('0);
            qz.push_back('0);
        end

        // Reset held two cycles under random inputs, then checked right after release.
        rst_n = 1'b0;
        rand_in(); step(0, 0, 0, 0, '0);
        rand_in(); step(1, 0, 0, 0, '0);
        rst_n = 1'b1;
        rand_in(); step(1, 1, 1'b0, 1'b0, 2'b00);

        apply(0, '0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, '0);
        apply(0, '0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, '0);

        for (int i = 0; i < 30; i++) begin
            apply(tbl[i].v, tbl[i].re, tbl[i].rs1, tbl[i].rs0, tbl[i].we, tbl[i].ws, tbl[i].fl);
            step(1, 1, tbl[i].st, tbl[i].zst, tbl[i].pd);
        end

`ifdef HAZARD_SCOREBOARD_PERF_EN
        perf_clr = 1'b1; apply(0, '0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, '0);
        perf_clr = 1'b0;
        apply(1, 2'b00, 0, 0, 1, 3, 0); step(1, 0, 0, 0, '0);
        repeat (3) begin apply(1, 2'b01, 0, 3, 0, 0, 0); step(1, 0, 0, 0, '0); end
        apply(1, 2'b00, 0, 0, 1, 5, 0); step(1, 0, 0, 0, '0);
        apply(1, 2'b00, 0, 0, 0, 0, 0); step(1, 0, 0, 0, '0);
        repeat (2) begin apply(1, 2'b01, 0, 5, 0, 0, 0); step(1, 0, 0, 0, '0); end
        chk("perf_three_stalls", cyc, 32'd3);

        force dut.stall_cnt = 16'hFFFE;
        #1;
        release dut.stall_cnt;
        m_cnt = 32'hFFFE;
        apply(1, 2'b00, 0, 0, 1, 3, 0); step(1, 0, 0, 0, '0);
        repeat (3) begin apply(1, 2'b01, 0, 3, 0, 0, 0); step(1, 0, 0, 0, '0); end
        apply(1, 2'b00, 0, 0, 1, 5, 0); step(1, 0, 0, 0, '0);
        apply(1, 2'b00, 0, 0, 0, 0, 0); step(1, 0, 0, 0, '0);
        repeat (2) begin apply(1, 2'b01, 0, 5, 0, 0, 0); step(1, 0, 0, 0, '0); end
        chk("perf_saturate", cyc, 32'hFFFF);

        perf_clr = 1'b1; apply(0, '0, 0, 0, 0, 0, 0); step(1, 0, 0, 0, '0);
        perf_clr = 1'b0;
        chk("perf_clear", cyc, 32'd0);
`endif

        for (int n = 0; n < 400; n++) begin
            rand_in();
            rst_n = ($urandom_range(0, 63) != 0);
`ifdef HAZARD_SCOREBOARD_PERF_EN
            perf_clr = ($urandom_range(0, 31) == 0);
`endif
            step(1, 0, 0, 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
